// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator sequencers: FSM encodings and default
// counter widths.
package accel_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int PASS_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FIN    = 2'd3
  } sched_state_e;

  // Phase A may request a word pair; phase B delivers the second word of a pair.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

endpackage

// File: rtl/sched_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement, and the
// count saturates at zero.
module sched_counter
  import accel_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/weight_fetch_sched.sv
// Streams weight words from the BRAM reader into the MAC array for a number of
// passes, requesting word pairs and rewinding the reader at the end of each pass.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | moving words reader -> MAC, one per transfer
// FLUSH  | abort: drain one pending word and rewind the reader
// FIN    | one-cycle done pulse
module weight_fetch_sched
  import accel_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [PASS_W-1:0] pass_count,
  input  logic              abort,
  input  logic              wt_valid,
  input  logic              mac_ready,
  output logic              rd_en,
  output logic              rd_len,
  output logic              addr_rst,
  output logic              mac_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_left
);

  sched_state_e state, state_nxt;
  phase_e       phase, phase_nxt;

  logic [CNT_W-1:0]  wc_lat;
  logic              lat_en;
  logic              w_load, w_dec, words_zero;
  logic [CNT_W-1:0]  w_load_val;
  logic              p_load, p_dec, passes_zero;
  logic [PASS_W-1:0] passes_left;
  logic [PASS_W-1:0] pass_reload;
  logic              last_word;

  // A pass count of zero runs the weight set once.
  assign pass_reload = (pass_count == '0) ? '0 : pass_count - 1'b1;
  assign last_word   = (words_left == CNT_W'(1));

  sched_counter #(.W(CNT_W)) u_words (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .count    (words_left),
    .zero     (words_zero)
  );

  sched_counter #(.W(PASS_W)) u_passes (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (p_load),
    .load_val (pass_reload),
    .dec      (p_dec),
    .count    (passes_left),
    .zero     (passes_zero)
  );

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    mac_valid  = 1'b0;
    rd_en      = 1'b0;
    rd_len     = 1'b0;
    addr_rst   = 1'b0;
    w_load     = 1'b0;
    w_load_val = wc_lat;
    w_dec      = 1'b0;
    p_load     = 1'b0;
    p_dec      = 1'b0;
    lat_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_nxt = ST_FIN;
          end else begin
            w_load     = 1'b1;
            w_load_val = word_count;
            p_load     = 1'b1;
            lat_en     = 1'b1;
            phase_nxt  = PH_A;
            state_nxt  = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (abort) begin
          state_nxt = ST_FLUSH;
        end else begin
          mac_valid = wt_valid;
          rd_en     = wt_valid & mac_ready;
          rd_len    = (phase == PH_A) && !words_zero && !last_word;
          if (rd_en) begin
            addr_rst = last_word;
            if (phase == PH_B) begin
              phase_nxt = PH_A;
            end else if (rd_len) begin
              phase_nxt = PH_B;
            end
            if (!last_word) begin
              w_dec = 1'b1;
            end else if (!passes_zero) begin
              // Next pass: rewind the word count from the latched job size.
              w_load = 1'b1;
              p_dec  = 1'b1;
            end else begin
              w_dec     = 1'b1;
              state_nxt = ST_FIN;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (wt_valid) begin
          rd_en     = 1'b1;
          addr_rst  = 1'b1;
          phase_nxt = PH_A;
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      phase  <= PH_A;
      wc_lat <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (lat_en) begin
        wc_lat <= word_count;
      end
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_FIN);
    end
  end

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Scoreboard bench for weight_fetch_sched with a behavioural BRAM reader whose
// word data is its current address.
module tb_weight_fetch_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  pass_count;
  logic        abort;
  logic        wt_valid;
  logic        mac_ready;
  logic        rd_en;
  logic        rd_len;
  logic        addr_rst;
  logic        mac_valid;
  logic        busy;
  logic        done;
  logic [15:0] words_left;

  weight_fetch_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .pass_count (pass_count),
    .abort      (abort),
    .wt_valid   (wt_valid),
    .mac_ready  (mac_ready),
    .rd_en      (rd_en),
    .rd_len     (rd_len),
    .addr_rst   (addr_rst),
    .mac_valid  (mac_valid),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  typedef struct {
    logic [15:0] data;
    logic        len;
    logic        ar;
    logic [15:0] wl;
  } sb_t;

  sb_t sb[$];
  sb_t head;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int xfer_cnt, stall_cnt, flush_cnt, done_cnt, rd_cnt;
  int last_xfer_cyc, flush_cyc, done_cyc, start_cyc;
  logic [15:0] flush_data_exp;
  logic [15:0] rd_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reader model: word data is the address; rewind on addr_rst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_addr <= '0;
    else if (rd_en) rd_addr <= addr_rst ? 16'd0 : rd_addr + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rd_en) rd_cnt++;
      if (mac_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          head = sb[0];
          chk("data", rd_addr, head.data);
          chk("words_left", words_left, head.wl);
          chk("rd_en_vs_ready", rd_en, mac_ready);
          if (rd_en) begin
            chk("rd_len", rd_len, head.len);
            chk("addr_rst", addr_rst, head.ar);
            void'(sb.pop_front());
            xfer_cnt++;
            last_xfer_cyc = cyc;
          end else begin
            stall_cnt++;
          end
        end
      end else if (rd_en) begin
        flush_cnt++;
        flush_cyc = cyc;
        chk("flush_addr_rst", addr_rst, 1);
        chk("flush_rd_len", rd_len, 0);
        chk("flush_data", rd_addr, flush_data_exp);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    xfer_cnt = 0; stall_cnt = 0; flush_cnt = 0; done_cnt = 0; rd_cnt = 0;
    last_xfer_cyc = -10; flush_cyc = -10; done_cyc = -10;
    sb.delete();
  endtask

  // Expected transfers of a job, optionally truncated to the first 'limit'.
  task automatic push_job(input int wc, input int pc, input int limit);
    int  np = (pc == 0) ? 1 : pc;
    int  n  = 0;
    bit  ph;
    sb_t e;
    for (int p = 0; p < np; p++) begin
      ph = 1'b0;
      for (int i = 0; i < wc; i++) begin
        e.wl   = 16'(wc - i);
        e.data = 16'(i);
        e.len  = (ph == 1'b0) && (wc - i >= 2);
        e.ar   = (wc - i == 1);
        if (n < limit) sb.push_back(e);
        n++;
        ph = e.len;
      end
    end
  endtask

  task automatic start_job(input int wc, input int pc);
    @(posedge clk); #1;
    start = 1'b1; word_count = 16'(wc); pass_count = 8'(pc);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (toggle) mac_ready = ~mac_ready;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt >= n) got = 1'b1;
    end
    chk("xfer_wait", got, 1);
  endtask

  task automatic run_job(input int wc, input int pc, input bit toggle);
    int np = (pc == 0) ? 1 : pc;
    clear_stats();
    push_job(wc, pc, 1 << 20);
    start_job(wc, pc);
    chk("busy_run", busy, 1);
    wait_done(200, toggle);
    mac_ready = 1'b1;
    chk("xfer_count", xfer_cnt, wc * np);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_cyc, last_xfer_cyc + 1);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; word_count = '0; pass_count = '0;
    abort = 1'b0; wt_valid = 1'b1; mac_ready = 1'b1; flush_data_exp = '0;
    clear_stats();
    @(negedge clk);
    chk("rst_outs", {rd_en, rd_len, addr_rst, mac_valid, busy, done}, 0);
    chk("rst_words_left", words_left, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(4, 1, 1'b0);
    run_job(3, 2, 1'b0);
    run_job(2, 0, 1'b0);

    run_job(5, 1, 1'b1);
    chk("stall_count", stall_cnt, 4);
    chk("words_left_end", words_left, 0);

    // Abort after the second transfer, in phase A.
    clear_stats();
    push_job(8, 1, 2);
    flush_data_exp = 16'd2;
    start_job(8, 1);
    wait_xfers(2, 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(50, 1'b0);
    chk("abort_xfers", xfer_cnt, 2);
    chk("abort_flush_cnt", flush_cnt, 1);
    chk("abort_done_latency", done_cyc, flush_cyc + 1);
    chk("abort_done_cnt", done_cnt, 1);
    chk("abort_sb_empty", sb.size(), 0);
    run_job(2, 1, 1'b0);

    // Zero-length job.
    clear_stats();
    start_job(0, 3);
    wait_done(20, 1'b0);
    chk("zero_done_latency", done_cyc, start_cyc + 1);
    chk("zero_rd_en", rd_cnt, 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Reset mid-pass.
    clear_stats();
    push_job(8, 1, 3);
    start_job(8, 1);
    wait_xfers(3, 50);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {rd_en, rd_len, addr_rst, mac_valid, busy, done}, 0);
    chk("midrst_words_left", words_left, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_done_cnt", done_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_xfers", xfer_cnt, 3);
    run_job(2, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
